// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the serial pattern generator.
// State encoding, default frame content and pulse levels live here.
package fsm_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam int unsigned PAT_W_DEF = 8;
   localparam int unsigned LEN_W_DEF = 4;
   localparam int unsigned REP_W_DEF = 8;
   localparam int unsigned GAP_W_DEF = 4;

   localparam logic [4:0]  DEF_PAT = 5'b10010;
   localparam int unsigned DEF_LEN = 5;

   localparam logic PULSE_ON  = 1'b1;
   localparam logic PULSE_OFF = 1'b0;

endpackage

// File: rtl/fsm_seq_gen_piso.sv
// Load/shift register for one frame plus its bit counter.
// The first bit of a frame bypasses the shifter, so sr_q holds only the bits still to come.
module seq_gen_piso
   import fsm_seq_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             reload_i,
   input  logic             shift_i,
   input  logic [PAT_W-1:0] pat_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             load_bit_o,
   output logic             first_bit_o,
   output logic             nxt_bit_o,
   output logic             last_bit_o
);

   logic [PAT_W-1:0] aligned;
   logic [LEN_W-1:0] shamt;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] sr_q;
   logic [LEN_W-1:0] lenm1_q;
   logic [LEN_W-1:0] cnt_q;

   // Left-justify the pattern so bit [len-1] lands on the MSB.
   assign shamt   = LEN_W'(PAT_W) - len_i;
   assign aligned = pat_i << shamt;

   assign load_bit_o  = aligned[PAT_W-1];
   assign first_bit_o = pat_q[PAT_W-1];
   assign nxt_bit_o   = sr_q[PAT_W-1];
   assign last_bit_o  = (cnt_q == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q   <= '0;
         sr_q    <= '0;
         lenm1_q <= '0;
         cnt_q   <= '0;
      end else if (load_i) begin
         pat_q   <= aligned;
         sr_q    <= {aligned[PAT_W-2:0], 1'b0};
         lenm1_q <= len_i - LEN_W'(1);
         cnt_q   <= len_i - LEN_W'(1);
      end else if (reload_i) begin
         sr_q    <= {pat_q[PAT_W-2:0], 1'b0};
         cnt_q   <= lenm1_q;
      end else if (shift_i) begin
         sr_q    <= {sr_q[PAT_W-2:0], 1'b0};
         cnt_q   <= cnt_q - LEN_W'(1);
      end
   end

endmodule

// File: rtl/fsm_seq_gen.sv
// Serial pattern generator: sends a latched pattern MSB-first, repeated with optional gaps.
// FSM, repeat/gap counters and the registered output stage.
module fsm_seq_gen
   import fsm_seq_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned LEN_W = LEN_W_DEF,
   parameter int unsigned REP_W = REP_W_DEF,
   parameter int unsigned GAP_W = GAP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic [REP_W-1:0] rep_in,
   input  logic [GAP_W-1:0] gap_in,
   input  logic             abort,
   output logic             data,
   output logic             data_vld,
   output logic             frame_start,
   output logic             busy,
   output logic             ready,
   output logic             done,
   output logic             err
);

   state_e state_q, state_d;

   logic [REP_W-1:0] rep_q, rep_d;
   logic             cont_q, cont_d;
   logic [GAP_W-1:0] gap_len_q, gap_len_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

   logic data_q, data_d;
   logic vld_q, vld_d;
   logic fs_q, fs_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic err_q, err_d;

   logic load, reload, shift;
   logic load_bit, first_bit, nxt_bit, last_bit;
   logic len_ok, more_frames;

   assign len_ok      = (len_in != '0) && (len_in <= LEN_W'(PAT_W));
   assign more_frames = cont_q || (rep_q > REP_W'(1));

   seq_gen_piso #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_piso (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load),
      .reload_i    (reload),
      .shift_i     (shift),
      .pat_i       (pat_in),
      .len_i       (len_in),
      .load_bit_o  (load_bit),
      .first_bit_o (first_bit),
      .nxt_bit_o   (nxt_bit),
      .last_bit_o  (last_bit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (start && len_ok) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) begin
                         if (!more_frames)          state_d = ST_IDLE;
                         else if (gap_len_q != '0)  state_d = ST_GAP;
                      end
            ST_GAP:   if (gap_cnt_q == '0) state_d = ST_SHIFT;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are computed one edge early and registered, so the accepting
   // edge already presents the first bit.
   always_comb begin
      data_d    = 1'b0;
      vld_d     = 1'b0;
      fs_d      = 1'b0;
      done_d    = PULSE_OFF;
      err_d     = PULSE_OFF;
      load      = 1'b0;
      reload    = 1'b0;
      shift     = 1'b0;
      rep_d     = rep_q;
      cont_d    = cont_q;
      gap_len_d = gap_len_q;
      gap_cnt_d = gap_cnt_q;
      if (!abort) begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     load      = 1'b1;
                     rep_d     = rep_in;
                     cont_d    = (rep_in == '0);
                     gap_len_d = gap_in;
                     data_d    = load_bit;
                     vld_d     = 1'b1;
                     fs_d      = 1'b1;
                  end else begin
                     err_d = PULSE_ON;
                  end
               end
            end
            ST_SHIFT: begin
               if (!last_bit) begin
                  shift  = 1'b1;
                  data_d = nxt_bit;
                  vld_d  = 1'b1;
               end else if (more_frames) begin
                  if (!cont_q) rep_d = rep_q - REP_W'(1);
                  if (gap_len_q == '0) begin
                     reload = 1'b1;
                     data_d = first_bit;
                     vld_d  = 1'b1;
                     fs_d   = 1'b1;
                  end else begin
                     gap_cnt_d = gap_len_q - GAP_W'(1);
                  end
               end else begin
                  done_d = PULSE_ON;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == '0) begin
                  reload = 1'b1;
                  data_d = first_bit;
                  vld_d  = 1'b1;
                  fs_d   = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q - GAP_W'(1);
               end
            end
            default: ;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_q     <= '0;
         cont_q    <= 1'b0;
         gap_len_q <= '0;
         gap_cnt_q <= '0;
         data_q    <= 1'b0;
         vld_q     <= 1'b0;
         fs_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rep_q     <= rep_d;
         cont_q    <= cont_d;
         gap_len_q <= gap_len_d;
         gap_cnt_q <= gap_cnt_d;
         data_q    <= data_d;
         vld_q     <= vld_d;
         fs_q      <= fs_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign data        = data_q;
   assign data_vld    = vld_q;
   assign frame_start = fs_q;
   assign busy        = busy_q;
   assign ready       = ~busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Directed bench for fsm_seq_gen: per-cycle output vectors compared against hand-derived values.
module tb_fsm_seq_gen;
   import fsm_seq_pkg::*;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] pat_in;
   logic [3:0] len_in;
   logic [7:0] rep_in;
   logic [3:0] gap_in;
   logic       abort;
   logic       data, data_vld, frame_start, busy, ready, done, err;

   int n_tests = 0;
   int n_fail  = 0;

   fsm_seq_gen #(
      .PAT_W (8),
      .LEN_W (4),
      .REP_W (8),
      .GAP_W (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .pat_in      (pat_in),
      .len_in      (len_in),
      .rep_in      (rep_in),
      .gap_in      (gap_in),
      .abort       (abort),
      .data        (data),
      .data_vld    (data_vld),
      .frame_start (frame_start),
      .busy        (busy),
      .ready       (ready),
      .done        (done),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Vector order: {data, data_vld, frame_start, busy, ready, done, err}
   task automatic now_is(input string tag, input logic d, input logic v, input logic f,
                         input logic b, input logic dn, input logic er);
      chk(tag, {25'd0, data, data_vld, frame_start, busy, ready, done, err},
               {25'd0, d, v, f, b, ~b, dn, er});
   endtask

   // One clock; start/abort act as single-cycle pulses.
   task automatic exp_out(input string tag, input logic d, input logic v, input logic f,
                          input logic b, input logic dn, input logic er);
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      now_is(tag, d, v, f, b, dn, er);
   endtask

   task automatic exp_frame(input string tag, input logic [7:0] pat, input int len);
      for (int i = len - 1; i >= 0; i--)
         exp_out(tag, pat[i], 1'b1, (i == len - 1), 1'b1, 1'b0, 1'b0);
   endtask

   task automatic exp_idle(input string tag, input int n, input logic b);
      for (int i = 0; i < n; i++)
         exp_out(tag, 1'b0, 1'b0, 1'b0, b, 1'b0, 1'b0);
   endtask

   task automatic setup(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r,
                        input logic [3:0] g);
      pat_in = p;
      len_in = l;
      rep_in = r;
      gap_in = g;
   endtask

   logic [7:0] dpat;

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      dpat  = 8'(DEF_PAT);
      setup(8'h00, 4'd0, 8'd0, 4'd0);
      #12;
      now_is("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      exp_idle("post_reset", 1, 1'b0);

      // 1: single frame 10010, done one cycle after last bit
      setup(8'h12, 4'(DEF_LEN), 8'd1, 4'd0);
      start = 1'b1;
      exp_frame("t1_frame", 8'h12, 5);
      exp_out("t1_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_idle("t1_after", 1, 1'b0);

      // 2: three frames with two idle cycles between
      setup(dpat, 4'd5, 8'd3, 4'd2);
      start = 1'b1;
      exp_frame("t2_f1", 8'h12, 5);
      exp_idle("t2_gap1", 2, 1'b1);
      exp_frame("t2_f2", 8'h12, 5);
      exp_idle("t2_gap2", 2, 1'b1);
      exp_frame("t2_f3", 8'h12, 5);
      exp_out("t2_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_idle("t2_after", 1, 1'b0);

      // 3: illegal lengths rejected
      setup(8'hA5, 4'd0, 8'd1, 4'd0);
      start = 1'b1;
      exp_out("t3_err_len0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_idle("t3_after0", 1, 1'b0);
      setup(8'hA5, 4'd9, 8'd1, 4'd0);
      start = 1'b1;
      exp_out("t3_err_len9", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_idle("t3_after9", 1, 1'b0);

      // 4: continuous stream, abort after 12 bits
      setup(dpat, 4'd5, 8'd0, 4'd0);
      start = 1'b1;
      exp_frame("t4_f1", 8'h12, 5);
      exp_frame("t4_f2", 8'h12, 5);
      exp_out("t4_b11", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_out("t4_b12", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      abort = 1'b1;
      exp_out("t4_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_idle("t4_after", 2, 1'b0);

      // abort and start together in IDLE: abort wins
      setup(8'h12, 4'd5, 8'd1, 4'd0);
      start = 1'b1;
      abort = 1'b1;
      exp_idle("abort_start", 2, 1'b0);

      // 5: start mid-frame with different inputs is ignored
      setup(8'h12, 4'd5, 8'd1, 4'd0);
      start = 1'b1;
      exp_out("t5_b1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_out("t5_b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      setup(8'hFF, 4'd3, 8'd4, 4'd1);
      start = 1'b1;
      exp_out("t5_b3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_out("t5_b4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_out("t5_b5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_out("t5_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_idle("t5_after", 1, 1'b0);

      // 6: async reset during 3rd bit, then normal restart
      setup(8'h12, 4'd5, 8'd1, 4'd0);
      start = 1'b1;
      exp_out("t6_b1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_out("t6_b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_out("t6_b3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      now_is("t6_async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      now_is("t6_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      exp_idle("t6_release", 1, 1'b0);
      setup(8'h0B, 4'd4, 8'd1, 4'd0);
      start = 1'b1;
      exp_frame("t6_restart", 8'h0B, 4);
      exp_out("t6_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Full-width frame, len = PAT_W, with a 1-cycle gap between two frames
      setup(8'hC5, 4'd8, 8'd2, 4'd1);
      start = 1'b1;
      exp_frame("w8_f1", 8'hC5, 8);
      exp_idle("w8_gap", 1, 1'b1);
      exp_frame("w8_f2", 8'hC5, 8);
      exp_out("w8_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Single-bit frames back-to-back
      setup(8'h01, 4'd1, 8'd3, 4'd0);
      start = 1'b1;
      exp_out("l1_f1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_out("l1_f2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_out("l1_f3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_out("l1_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_idle("l1_after", 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
